inst_axi_rd_bridge: RTL and testbench

Read-only bridge between the IF stage's SRAM-like instruction port and the AXI read channels feeding the instruction memory. It accepts a fetch request when the IF stage asserts `inst_sram_req`, acknowledges it with `inst_sram_addr_ok`, and issues a single-beat AXI read. It returns the fetched word in order with `inst_sram_data_ok`, keeping a bounded number of reads outstanding.

---
 rtl/inst_axi_rd_bridge.sv | 172 +++++++++++++++++
 tb/tb_inst_axi_rd_bridge.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_axi_rd_bridge.sv
// inst_axi_rd_bridge
// Read-only bridge from the IF stage's SRAM-like instruction port to the AXI
// AR/R channels. Each accepted fetch becomes one single-beat AXI read, and
// the returned words go back to the IF stage in request order. The number of
// accepted-but-not-returned fetches is limited to MAX_OUT.
//
// Optional build macro: INST_BRIDGE_RBUF_EN
//   defined   : data_ok/rdata are registered, which adds one cycle after the
//               R handshake. The outstanding counter then retires on the
//               registered data_ok.
//   undefined : data_ok/rdata come straight from rvalid/rdata.
module inst_axi_rd_bridge #(
    parameter int         MAX_OUT  = 2,
    parameter logic [3:0] ARID_VAL = 4'd0
) (
    input  logic        clk,
    input  logic        reset,

    // SRAM-like instruction port
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    // AXI AR channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    // AXI R channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    // Outstanding counter is sized to hold the value MAX_OUT itself.
    localparam int            CW      = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);

    // AR holding register: one pending read address waiting for arready.
    logic          ar_pend_q, ar_pend_d;
    logic [31:0]   ar_addr_q, ar_addr_d;
    logic [1:0]    ar_size_q, ar_size_d;

    // Fetches that were acknowledged with addr_ok but not yet returned.
    logic [CW-1:0] cnt_q, cnt_d;

    logic          accept;
    logic          retire;
    logic          unused_ok;

    // The write path and the R-channel sideband are not used by an
    // instruction fetch bridge. rid/rresp/rlast are ignored on purpose: one
    // ARID keeps the beats in order, and the IF stage deals with bus errors.
    assign unused_ok = ^{inst_sram_wstrb, inst_sram_wdata, rid, rresp, rlast};

    // A new fetch is taken only when the AR register is free (or frees this
    // very cycle through arready) and the registered counter has room. Using
    // the registered count means a data_ok in the same cycle does not open
    // a slot until the following cycle.
    assign accept = inst_sram_req & ~inst_sram_wr
                  & (~ar_pend_q | arready)
                  & (cnt_q < MAX_CNT);

    assign inst_sram_addr_ok = accept;

    // AR channel is driven straight from the holding register, so the
    // request stays stable for as long as arready is low.
    assign arvalid = ar_pend_q;
    assign araddr  = ar_addr_q;
    assign arsize  = {1'b0, ar_size_q};
    assign arid    = ARID_VAL;
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    // The IF stage never back-pressures returned data, so R is always ready.
    assign rready  = 1'b1;

`ifdef INST_BRIDGE_RBUF_EN
    logic        data_ok_q;
    logic [31:0] rdata_q;

    // Registered return path: capture each R beat for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_ok_q <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            data_ok_q <= rvalid;
            if (rvalid) begin
                rdata_q <= rdata;
            end
        end
    end

    assign inst_sram_data_ok = data_ok_q;
    assign inst_sram_rdata   = rdata_q;
    assign retire            = data_ok_q;
`else
    // Combinational return path: an R beat is handed to the IF stage in the
    // same cycle it arrives.
    assign inst_sram_data_ok = rvalid;
    assign inst_sram_rdata   = rdata;
    assign retire            = rvalid;
`endif

    // Next-state for the AR holding register. A new accept overrides the
    // clear caused by a handshake, which allows back-to-back requests.
    always_comb begin
        ar_pend_d = ar_pend_q;
        ar_addr_d = ar_addr_q;
        ar_size_d = ar_size_q;
        if (accept) begin
            ar_pend_d = 1'b1;
            ar_addr_d = inst_sram_addr;
            ar_size_d = inst_sram_size;
        end else if (arready) begin
            ar_pend_d = 1'b0;
        end
    end

    // Next-state for the outstanding counter. An accept and a retire in the
    // same cycle cancel out. The guards keep the count within 0..MAX_OUT
    // even if the slave misbehaves.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && !retire) begin
            if (cnt_q != MAX_CNT) begin
                cnt_d = cnt_q + ONE_CNT;
            end
        end else if (retire && !accept) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - ONE_CNT;
            end
        end
    end

    // State registers for the AR holding register and the outstanding count.
    always_ff @(posedge clk) begin
        if (reset) begin
            ar_pend_q <= 1'b0;
            ar_addr_q <= 32'd0;
            ar_size_q <= 2'd0;
            cnt_q     <= '0;
        end else begin
            ar_pend_q <= ar_pend_d;
            ar_addr_q <= ar_addr_d;
            ar_size_q <= ar_size_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Testbench for inst_axi_rd_bridge, default build (combinational return path).
// Directed scenarios come first, followed by a randomized run that is checked
// against a transaction-level model built from queues.
module tb_inst_axi_rd_bridge;

    localparam int         MAX_OUT = 2;
    localparam logic [3:0] ARID    = 4'h5;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    inst_axi_rd_bridge #(.MAX_OUT(MAX_OUT), .ARID_VAL(ARID)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    // Word the bench's AXI slave returns for a given address.
    function automatic logic [31:0] dataOf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Inputs change on the falling edge; checks happen #1 later.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleInputs;
        reset = 1'b0; inst_sram_req = 1'b0; inst_sram_wr = 1'b0;
        inst_sram_size = 2'd2; inst_sram_wstrb = 4'd0; inst_sram_addr = 32'd0;
        inst_sram_wdata = 32'd0; arready = 1'b0; rid = 4'd0; rdata = 32'd0;
        rresp = 2'd0; rlast = 1'b1; rvalid = 1'b0;
    endtask

    task automatic doReset;
        idleInputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    // Reset values, both while reset is held and right after it is released.
    task automatic test_reset;
        idleInputs();
        reset = 1'b1;
        tick(); tick();
        #1;
        vectors++; if (arvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_arvalid got %b want 0", arvalid); end
        vectors++; if (inst_sram_data_ok !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_data_ok got %b want 0", inst_sram_data_ok); end
        vectors++; if (inst_sram_addr_ok !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_addr_ok got %b want 0", inst_sram_addr_ok); end
        vectors++; if (dut.cnt_q !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_cnt got %0d want 0", dut.cnt_q); end
        vectors++; if (rready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_rready got %b want 1", rready); end
        reset = 1'b0;
        tick();
        #1;
        vectors++; if (arvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_arvalid got %b want 0", arvalid); end
        vectors++; if (rready !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_rready got %b want 1", rready); end
    endtask

    // One fetch end to end, with every AR field checked.
    task automatic test_single_fetch;
        doReset();
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0000; inst_sram_size = 2'd2; arready = 1'b1;
        #1;
        vectors++; if (inst_sram_addr_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL single_addr_ok got %b want 1", inst_sram_addr_ok); end
        vectors++; if (arvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_arvalid_t got %b want 0", arvalid); end
        tick();
        inst_sram_req = 1'b0;
        #1;
        vectors++; if (arvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL single_arvalid got %b want 1", arvalid); end
        vectors++; if (araddr !== 32'h1C00_0000) begin miscompares++; $display("[TB] FAIL single_araddr got %h want 1c000000", araddr); end
        vectors++; if (arsize !== 3'b010) begin miscompares++; $display("[TB] FAIL single_arsize got %b want 010", arsize); end
        vectors++; if (arlen !== 8'd0 || arburst !== 2'b01) begin miscompares++; $display("[TB] FAIL single_arlen_burst got %h/%b want 00/01", arlen, arburst); end
        vectors++; if (arid !== ARID) begin miscompares++; $display("[TB] FAIL single_arid got %h want %h", arid, ARID); end
        vectors++; if ({arlock, arcache, arprot} !== 9'd0) begin miscompares++; $display("[TB] FAIL single_lock_cache_prot got %h want 0", {arlock, arcache, arprot}); end
        tick();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h0280_0C00;
        #1;
        vectors++; if (inst_sram_data_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL single_data_ok got %b want 1", inst_sram_data_ok); end
        vectors++; if (inst_sram_rdata !== 32'h0280_0C00) begin miscompares++; $display("[TB] FAIL single_rdata got %h want 02800c00", inst_sram_rdata); end
        vectors++; if (arvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_arvalid_drop got %b want 0", arvalid); end
        tick();
        rvalid = 1'b0;
        #1;
        vectors++; if (dut.cnt_q !== 2'd0) begin miscompares++; $display("[TB] FAIL single_cnt got %0d want 0", dut.cnt_q); end
    endtask

    // AR stalls for five cycles; the second request waits for arready.
    task automatic test_ar_stall;
        doReset();
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0040; arready = 1'b0;
        #1;
        vectors++; if (inst_sram_addr_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_first_addr_ok got %b want 1", inst_sram_addr_ok); end
        tick();
        inst_sram_addr = 32'h1C00_0044;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++; if (arvalid !== 1'b1 || araddr !== 32'h1C00_0040) begin miscompares++; $display("[TB] FAIL stall_hold arvalid %b araddr %h want 1 1c000040", arvalid, araddr); end
            vectors++; if (inst_sram_addr_ok !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_blocked got %b want 0", inst_sram_addr_ok); end
            tick();
        end
        arready = 1'b1;
        #1;
        vectors++; if (inst_sram_addr_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_release_addr_ok got %b want 1", inst_sram_addr_ok); end
        tick();
        inst_sram_req = 1'b0;
        #1;
        vectors++; if (arvalid !== 1'b1 || araddr !== 32'h1C00_0044) begin miscompares++; $display("[TB] FAIL stall_second_ar arvalid %b araddr %h want 1 1c000044", arvalid, araddr); end
        tick();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h1111_1111;
        #1;
        vectors++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h1111_1111) begin miscompares++; $display("[TB] FAIL stall_data0 ok %b data %h want 1 11111111", inst_sram_data_ok, inst_sram_rdata); end
        tick();
        rdata = 32'h2222_2222;
        #1;
        vectors++; if (inst_sram_rdata !== 32'h2222_2222) begin miscompares++; $display("[TB] FAIL stall_data1 got %h want 22222222", inst_sram_rdata); end
        tick();
        rvalid = 1'b0;
        #1;
        vectors++; if (dut.cnt_q !== 2'd0) begin miscompares++; $display("[TB] FAIL stall_cnt got %0d want 0", dut.cnt_q); end
    endtask

    // Two reads in flight fill the bridge; the third waits for a return.
    task automatic test_full;
        doReset();
        inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_1000; arready = 1'b1;
        #1;
        vectors++; if (inst_sram_addr_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL full_acc0 got %b want 1", inst_sram_addr_ok); end
        tick();
        inst_sram_addr = 32'h0000_1004;
        #1;
        vectors++; if (inst_sram_addr_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL full_acc1 got %b want 1", inst_sram_addr_ok); end
        tick();
        inst_sram_addr = 32'h0000_1008;
        #1;
        vectors++; if (inst_sram_addr_ok !== 1'b0) begin miscompares++; $display("[TB] FAIL full_block0 got %b want 0", inst_sram_addr_ok); end
        tick();
        #1;
        vectors++; if (dut.cnt_q !== 2'd2) begin miscompares++; $display("[TB] FAIL full_cnt got %0d want 2", dut.cnt_q); end
        vectors++; if (inst_sram_addr_ok !== 1'b0) begin miscompares++; $display("[TB] FAIL full_block1 got %b want 0", inst_sram_addr_ok); end
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h0000_00DA;
        #1;
        vectors++; if (inst_sram_data_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL full_data_a got %b want 1", inst_sram_data_ok); end
        vectors++; if (inst_sram_addr_ok !== 1'b0) begin miscompares++; $display("[TB] FAIL full_same_cycle got %b want 0", inst_sram_addr_ok); end
        tick();
        rvalid = 1'b0;
        #1;
        vectors++; if (inst_sram_addr_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL full_reopen got %b want 1", inst_sram_addr_ok); end
        tick();
        inst_sram_req = 1'b0; arready = 1'b1; rvalid = 1'b1; rdata = 32'h0000_00DB;
        #1;
        vectors++; if (inst_sram_rdata !== 32'h0000_00DB) begin miscompares++; $display("[TB] FAIL full_data_b got %h want 000000db", inst_sram_rdata); end
        vectors++; if (arvalid !== 1'b1 || araddr !== 32'h0000_1008) begin miscompares++; $display("[TB] FAIL full_third_ar arvalid %b araddr %h want 1 00001008", arvalid, araddr); end
        tick();
        arready = 1'b0; rdata = 32'h0000_00DC;
        #1;
        vectors++; if (inst_sram_rdata !== 32'h0000_00DC) begin miscompares++; $display("[TB] FAIL full_data_c got %h want 000000dc", inst_sram_rdata); end
        tick();
        rvalid = 1'b0;
        #1;
        vectors++; if (dut.cnt_q !== 2'd0) begin miscompares++; $display("[TB] FAIL full_cnt_end got %0d want 0", dut.cnt_q); end
    endtask

    // Accept and return in the same cycle leave the count unchanged.
    task automatic test_simultaneous;
        doReset();
        inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_2000; arready = 1'b1;
        #1;
        vectors++; if (inst_sram_addr_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL sim_acc0 got %b want 1", inst_sram_addr_ok); end
        tick();
        inst_sram_req = 1'b0;
        tick();
        inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_2004; rvalid = 1'b1; rdata = 32'h0000_000A;
        #1;
        vectors++; if (dut.cnt_q !== 2'd1) begin miscompares++; $display("[TB] FAIL sim_cnt_before got %0d want 1", dut.cnt_q); end
        vectors++; if (inst_sram_addr_ok !== 1'b1 || inst_sram_data_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL sim_both addr_ok %b data_ok %b want 1 1", inst_sram_addr_ok, inst_sram_data_ok); end
        vectors++; if (inst_sram_rdata !== 32'h0000_000A) begin miscompares++; $display("[TB] FAIL sim_data_a got %h want 0000000a", inst_sram_rdata); end
        tick();
        inst_sram_req = 1'b0; rvalid = 1'b0;
        #1;
        vectors++; if (dut.cnt_q !== 2'd1) begin miscompares++; $display("[TB] FAIL sim_cnt_after got %0d want 1", dut.cnt_q); end
        vectors++; if (arvalid !== 1'b1 || araddr !== 32'h0000_2004) begin miscompares++; $display("[TB] FAIL sim_ar arvalid %b araddr %h want 1 00002004", arvalid, araddr); end
        tick();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_000B;
        #1;
        vectors++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h0000_000B) begin miscompares++; $display("[TB] FAIL sim_data_b ok %b data %h want 1 0000000b", inst_sram_data_ok, inst_sram_rdata); end
        tick();
        rvalid = 1'b0;
        #1;
        vectors++; if (dut.cnt_q !== 2'd0) begin miscompares++; $display("[TB] FAIL sim_cnt_end got %0d want 0", dut.cnt_q); end
    endtask

    // Writes are refused; an error response is still forwarded as data.
    task automatic test_wr_and_rresp;
        doReset();
        inst_sram_req = 1'b1; inst_sram_wr = 1'b1; arready = 1'b1; inst_sram_addr = 32'h0000_3000;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++; if (inst_sram_addr_ok !== 1'b0 || arvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_refused addr_ok %b arvalid %b want 0 0", inst_sram_addr_ok, arvalid); end
            tick();
        end
        inst_sram_wr = 1'b0; inst_sram_addr = 32'h0000_3004;
        #1;
        vectors++; if (inst_sram_addr_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_read_acc got %b want 1", inst_sram_addr_ok); end
        tick();
        inst_sram_req = 1'b0;
        #1;
        vectors++; if (araddr !== 32'h0000_3004) begin miscompares++; $display("[TB] FAIL wr_read_araddr got %h want 00003004", araddr); end
        tick();
        arready = 1'b0; rvalid = 1'b1; rresp = 2'b10; rid = 4'h9; rlast = 1'b0; rdata = 32'hDEAD_BEEF;
        #1;
        vectors++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL rresp_forward ok %b data %h want 1 deadbeef", inst_sram_data_ok, inst_sram_rdata); end
        tick();
        idleInputs();
        #1;
        vectors++; if (dut.cnt_q !== 2'd0) begin miscompares++; $display("[TB] FAIL rresp_cnt got %0d want 0", dut.cnt_q); end
    endtask

    // Reset with two reads in flight and one AR pending.
    task automatic test_reset_mid;
        doReset();
        inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_4000; arready = 1'b1;
        tick();
        inst_sram_addr = 32'h0000_4004;
        tick();
        inst_sram_req = 1'b0; arready = 1'b0; reset = 1'b1;
        #1;
        vectors++; if (dut.cnt_q !== 2'd2 || arvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_before cnt %0d arvalid %b want 2 1", dut.cnt_q, arvalid); end
        tick();
        reset = 1'b0; inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_4010; arready = 1'b1;
        #1;
        vectors++; if (arvalid !== 1'b0 || dut.cnt_q !== 2'd0) begin miscompares++; $display("[TB] FAIL rstmid_cleared arvalid %b cnt %0d want 0 0", arvalid, dut.cnt_q); end
        vectors++; if (inst_sram_addr_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_accept got %b want 1", inst_sram_addr_ok); end
        tick();
        inst_sram_req = 1'b0;
        #1;
        vectors++; if (arvalid !== 1'b1 || araddr !== 32'h0000_4010) begin miscompares++; $display("[TB] FAIL rstmid_ar arvalid %b araddr %h want 1 00004010", arvalid, araddr); end
        tick();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_4444;
        tick();
        idleInputs();
        #1;
        vectors++; if (dut.cnt_q !== 2'd0) begin miscompares++; $display("[TB] FAIL rstmid_cnt_end got %0d want 0", dut.cnt_q); end
    endtask

    // Random traffic against a transaction-level model: a queue of fetches
    // in request order, a slot for the fetch still waiting on AR, and a
    // slave queue of addresses that completed the AR handshake.
    task automatic test_random;
        logic [31:0] orderQ[$];
        logic [31:0] slaveQ[$];
        logic [31:0] pendAddr;
        logic [1:0]  pendSize;
        logic [31:0] a;
        logic [31:0] want;
        bit          pend;
        bit          expOk;
        int          outstanding;
        doReset();
        pend = 1'b0; outstanding = 0; pendAddr = 32'd0; pendSize = 2'd0;
        for (int c = 0; c < 660; c++) begin
            a = $urandom();
            a[1:0] = 2'b00;
            inst_sram_addr = a;
            inst_sram_size = 2'($urandom_range(0, 2));
            inst_sram_wdata = $urandom();
            rid = 4'($urandom_range(0, 15));
            rresp = 2'($urandom_range(0, 3));
            if (c < 600) begin
                inst_sram_req = ($urandom_range(0, 3) != 0);
                inst_sram_wr = ($urandom_range(0, 7) == 0);
                arready = ($urandom_range(0, 1) == 1);
                rvalid = (slaveQ.size() > 0) && ($urandom_range(0, 2) != 0);
            end else begin
                inst_sram_req = 1'b0; inst_sram_wr = 1'b0; arready = 1'b1;
                rvalid = (slaveQ.size() > 0);
            end
            rdata = rvalid ? dataOf(slaveQ[0]) : 32'($urandom());
            #1;
            expOk = inst_sram_req && !inst_sram_wr && (!pend || arready) && (outstanding < MAX_OUT);
            vectors++; if (inst_sram_addr_ok !== expOk) begin miscompares++; $display("[TB] FAIL rnd_addr_ok cycle %0d got %b want %b", c, inst_sram_addr_ok, expOk); end
            vectors++; if (arvalid !== pend) begin miscompares++; $display("[TB] FAIL rnd_arvalid cycle %0d got %b want %b", c, arvalid, pend); end
            if (pend) begin
                vectors++; if (araddr !== pendAddr || arsize !== {1'b0, pendSize}) begin miscompares++; $display("[TB] FAIL rnd_ar cycle %0d got %h/%b want %h/%b", c, araddr, arsize, pendAddr, {1'b0, pendSize}); end
            end
            vectors++; if (inst_sram_data_ok !== rvalid) begin miscompares++; $display("[TB] FAIL rnd_data_ok cycle %0d got %b want %b", c, inst_sram_data_ok, rvalid); end
            if (rvalid) begin
                want = dataOf(orderQ[0]);
                vectors++; if (inst_sram_rdata !== want) begin miscompares++; $display("[TB] FAIL rnd_rdata cycle %0d got %h want %h", c, inst_sram_rdata, want); end
            end
            @(posedge clk);
            if (rvalid) begin
                void'(slaveQ.pop_front());
                void'(orderQ.pop_front());
                outstanding--;
            end
            if (pend && arready) begin
                slaveQ.push_back(pendAddr);
                pend = 1'b0;
            end
            if (expOk) begin
                pend = 1'b1;
                pendAddr = a;
                pendSize = inst_sram_size;
                orderQ.push_back(a);
                outstanding++;
            end
            @(negedge clk);
        end
        idleInputs();
        #1;
        vectors++; if (outstanding != 0 || dut.cnt_q !== 2'd0) begin miscompares++; $display("[TB] FAIL rnd_drain model %0d dut cnt %0d want 0 0", outstanding, dut.cnt_q); end
    endtask

    initial begin
        idleInputs();
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_fetch();
        test_ar_stall();
        test_full();
        test_simultaneous();
        test_wr_and_rresp();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
